// File: rtl/llc_arb_pkg.sv
// Shared types and defaults for the LLC request arbiter: cache operation codes,
// arbiter FSM states and the response error helper.
package llc_arb_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_CACHE_LAT = 1;
    localparam int CNT_W         = 3;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_2     = 2'd2,
        OP_3     = 2'd3
    } llc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // A cache that reports both or neither of hit/miss gave no usable answer.
    function automatic logic resp_err_f(input logic hit, input logic miss);
        return (hit == miss);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the requester just after last_grant_i has
// highest priority, last_grant_i itself the lowest.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    // Scan from lowest to highest priority so the nearest requester overwrites.
    always_comb begin
        int         cand;
        logic [IDX_W-1:0] cand_idx;
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand     = (int'(last_grant_i) + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req_i[cand_idx]) begin
                grant_idx_o = cand_idx;
                any_o       = 1'b1;
            end else begin
                grant_idx_o = grant_idx_o;
            end
        end
        if (any_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end else begin
            grant_o = '0;
        end
    end

endmodule

// File: rtl/llc_req_arbiter.sv
// Shares one cache port among NUM_REQ requesters, one request in flight at a time.
// Optional per-requester grant and hit statistics under macro LLC_ARB_STATS_EN.
module llc_req_arbiter
    import llc_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ADDR_W    = 32,
    parameter int CACHE_LAT = DEF_CACHE_LAT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][1:0]        req_op,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           cache_valid,
    output logic [ADDR_W-1:0]              cache_address,
    output logic [1:0]                     cache_operation,
    input  logic                           cache_hit,
    input  logic                           cache_miss,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic                           resp_hit,
    output logic                           resp_err
`ifdef LLC_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][31:0]       grant_count,
    output logic [31:0]                    hit_count
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    llc_op_e             op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  arb_grant_s;
    logic [IDX_W-1:0]    arb_idx_s;
    logic                arb_any_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant_s),
        .grant_idx_o  (arb_idx_s),
        .any_o        (arb_any_s)
    );

    // State, grant pointer, captured request and latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            gidx_q       <= '0;
            addr_q       <= '0;
            op_q         <= OP_READ;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gidx_q       <= gidx_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next state and outputs; everything is forced quiet while reset is high.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        gidx_d          = gidx_q;
        addr_d          = addr_q;
        op_d            = op_q;
        cnt_d           = cnt_q;
        req_ready       = '0;
        cache_valid     = 1'b0;
        cache_address   = '0;
        cache_operation = 2'd0;
        resp_valid      = '0;
        resp_hit        = 1'b0;
        resp_err        = 1'b0;
        if (reset) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_any_s) begin
                        req_ready    = arb_grant_s;
                        last_grant_d = arb_idx_s;
                        gidx_d       = arb_idx_s;
                        addr_d       = req_addr[arb_idx_s];
                        op_d         = llc_op_e'(req_op[arb_idx_s]);
                        state_d      = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cache_valid     = 1'b1;
                    cache_address   = addr_q;
                    cache_operation = op_q;
                    cnt_d           = CNT_W'(CACHE_LAT);
                    state_d         = ST_WAIT;
                end
                ST_WAIT: begin
                    cache_address   = addr_q;
                    cache_operation = op_q;
                    // A counter of 0 can only appear if CACHE_LAT is misconfigured; respond anyway.
                    if (cnt_q <= CNT_W'(1)) begin
                        resp_valid = NUM_REQ'(1) << gidx_q;
                        resp_hit   = cache_hit;
                        resp_err   = resp_err_f(cache_hit, cache_miss);
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

`ifdef LLC_ARB_STATS_EN
    logic accept_s;
    logic resp_fire_s;

    assign accept_s    = |req_ready;
    assign resp_fire_s = |resp_valid;

    // Free-running statistics; counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count <= '0;
            hit_count   <= '0;
        end else begin
            if (accept_s) begin
                grant_count[arb_idx_s] <= grant_count[arb_idx_s] + 32'd1;
            end else begin
                grant_count <= grant_count;
            end
            if (resp_fire_s && resp_hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                hit_count <= hit_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_llc_req_arbiter.sv
// Self-checking bench for llc_req_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a request-lifetime model.
module tb_llc_req_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int LAT = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N-1:0]           req_valid;
    logic [N-1:0][AW-1:0]   req_addr;
    logic [N-1:0][1:0]      req_op;
    logic [N-1:0]           req_ready;
    logic                   cache_valid;
    logic [AW-1:0]          cache_address;
    logic [1:0]             cache_operation;
    logic                   cache_hit;
    logic                   cache_miss;
    logic [N-1:0]           resp_valid;
    logic                   resp_hit;
    logic                   resp_err;
`ifdef LLC_ARB_STATS_EN
    logic [N-1:0][31:0]     grant_count;
    logic [31:0]            hit_count;
`endif

    llc_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .CACHE_LAT(LAT)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_op          (req_op),
        .req_ready       (req_ready),
        .cache_valid     (cache_valid),
        .cache_address   (cache_address),
        .cache_operation (cache_operation),
        .cache_hit       (cache_hit),
        .cache_miss      (cache_miss),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit),
        .resp_err        (resp_err)
`ifdef LLC_ARB_STATS_EN
        ,
        .grant_count     (grant_count),
        .hit_count       (hit_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a request is alive for LAT+1 cycles after the cycle it is accepted.
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    int          m_g    = 0;
    int          m_last = N - 1;
    logic [31:0] m_addr = '0;
    logic [1:0]  m_op   = '0;
    int          acc_now = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    task automatic sample();
        logic [N-1:0] e_ready, e_rv;
        logic         e_cv, e_hit, e_err;
        logic [31:0]  e_addr;
        logic [1:0]   e_op;
        int           w, c;
        @(negedge clk);
        e_ready = '0; e_rv = '0; e_cv = 1'b0; e_hit = 1'b0; e_err = 1'b0;
        e_addr = '0; e_op = '0; acc_now = -1; w = -1;
        if (reset) begin
            m_busy = 1'b0; m_last = N - 1; m_age = 0;
        end else if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (w < 0 && req_valid[c]) w = c;
            end
            if (w >= 0) begin
                e_ready[w] = 1'b1;
                m_busy = 1'b1; m_age = 0; m_g = w;
                m_addr = req_addr[w]; m_op = req_op[w];
                m_last = w; acc_now = w;
            end
        end else begin
            m_age++;
            e_cv   = (m_age == 1);
            e_addr = m_addr;
            e_op   = m_op;
            if (m_age == LAT + 1) begin
                e_rv[m_g] = 1'b1;
                e_hit     = cache_hit;
                e_err     = (cache_hit == cache_miss);
                m_busy    = 1'b0;
            end
        end
        chk("req_ready", req_ready, e_ready);
        chk("cache_valid", cache_valid, e_cv);
        chk("cache_address", cache_address, e_addr);
        chk("cache_operation", cache_operation, e_op);
        chk("resp_valid", resp_valid, e_rv);
        chk("resp_hit", resp_hit, e_hit);
        chk("resp_err", resp_err, e_err);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic run_one(input int idx, input logic h, input logic m,
                           output logic [N-1:0] rv, output logic rh, output logic re, output bit ok);
        bit acc, done;
        acc = 1'b0; done = 1'b0; rv = '0; rh = 1'b0; re = 1'b0;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_addr[idx]  = $urandom;
        req_op[idx]    = 2'($urandom_range(0, 3));
        cache_hit = h; cache_miss = m;
        for (int t = 0; t < 60 && !done; t++) begin
            sample();
            if (!acc && req_ready != '0) begin
                acc = 1'b1;
            end else if (acc && resp_valid != '0) begin
                rv = resp_valid; rh = resp_hit; re = resp_err; done = 1'b1;
            end
            advance();
            if (acc) req_valid = '0;
        end
        ok = done;
    endtask

    initial begin
        int          got[$];
        int          gcyc[$];
        logic [N-1:0] rv;
        logic        rh, re;
        bit          ok, seen;
        int          acc_last;

        reset = 1'b1; req_valid = '0; req_addr = '0; req_op = '0;
        cache_hit = 1'b0; cache_miss = 1'b0;
        step(); step();
        reset = 1'b0;

        // Single read from requester 0 with a hit.
        req_valid = 4'b0001; req_addr[0] = 32'h0000_1000; req_op[0] = 2'd0;
        cache_hit = 1'b1; cache_miss = 1'b0;
        sample(); chk("t1_ready", req_ready, 4'b0001); advance();
        req_valid = '0;
        sample(); chk("t1_cv", cache_valid, 1'b1); chk("t1_addr", cache_address, 32'h0000_1000); advance();
        for (int i = 0; i < LAT - 1; i++) begin
            sample(); chk("t1_no_resp", resp_valid, 4'b0000); advance();
        end
        sample(); chk("t1_resp", resp_valid, 4'b0001); chk("t1_hit", resp_hit, 1'b1); advance();
        sample(); chk("t1_idle_addr", cache_address, 32'h0); advance();

        // Continuous load from all four requesters.
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = 32'h100 * (i + 1);
            req_op[i]   = 2'(i);
        end
        req_valid = 4'b1111;
        for (int t = 0; t < 200 && got.size() < 8; t++) begin
            sample();
            if (req_ready != '0) begin
                got.push_back(oh(req_ready));
                gcyc.push_back(t);
            end
            advance();
        end
        chk("t2_count", got.size(), 8);
        for (int i = 0; i < got.size(); i++) chk("t2_order", got[i], i % 4);
        for (int i = 1; i < gcyc.size(); i++) chk("t2_spacing", gcyc[i] - gcyc[i-1], LAT + 2);

        // Wrap-around with requesters 1 and 3 after the grant to 3.
        req_valid = 4'b1010;
        got.delete();
        for (int t = 0; t < 100 && got.size() < 2; t++) begin
            sample();
            if (req_ready != '0) got.push_back(oh(req_ready));
            advance();
        end
        chk("t3_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t3_first", got[0], 1);
            chk("t3_second", got[1], 3);
        end else begin
            chk("t3_missing", got.size(), 2);
        end
        req_valid = '0;

        // Error and miss responses.
        run_one(2, 1'b1, 1'b1, rv, rh, re, ok);
        chk("t4a_done", ok, 1'b1); chk("t4a_rv", rv, 4'b0100); chk("t4a_err", re, 1'b1);
        run_one(2, 1'b0, 1'b1, rv, rh, re, ok);
        chk("t4b_done", ok, 1'b1); chk("t4b_rv", rv, 4'b0100);
        chk("t4b_hit", rh, 1'b0); chk("t4b_err", re, 1'b0);

        // Reset while requester 2 is waiting on the cache.
        req_valid = 4'b0100; seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            sample(); seen = (req_ready == 4'b0100); advance();
        end
        req_valid = '0;
        chk("t5_acc", seen, 1'b1);
        step();
        reset = 1'b1;
        sample(); chk("t5_rv_in_reset", resp_valid, 4'b0000); advance();
        reset = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            sample(); chk("t5_no_resp", resp_valid, 4'b0000); advance();
        end
        req_valid = 4'b1001;
        sample(); chk("t5_grant0", req_ready, 4'b0001); advance();
        req_valid = '0;
        for (int i = 0; i < LAT + 2; i++) step();

`ifdef LLC_ARB_STATS_EN
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_one(1, (i < 3) ? 1'b1 : 1'b0, (i < 3) ? 1'b0 : 1'b1, rv, rh, re, ok);
            chk("t6_done", ok, 1'b1);
        end
        sample();
        chk("t6_grant1", grant_count[1], 32'd5);
        chk("t6_grant0", grant_count[0], 32'd0);
        chk("t6_hits", hit_count, 32'd3);
        advance();
        reset = 1'b1; step(); reset = 1'b0;
        sample(); chk("t6_clr_grant", grant_count[1], 32'd0); chk("t6_clr_hits", hit_count, 32'd0); advance();
`endif

        // Randomized traffic, including occasional drops and resets.
        reset = 1'b1; step(); reset = 1'b0;
        acc_last = -1;
        for (int t = 0; t < 3000; t++) begin
            cache_hit  = 1'($urandom_range(0, 1));
            cache_miss = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                if (acc_last == i || !req_valid[i]) begin
                    req_valid[i] = 1'b0;
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_addr[i]  = $urandom;
                        req_op[i]    = 2'($urandom_range(0, 3));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            reset = ($urandom_range(0, 499) == 0);
            sample();
            acc_last = acc_now;
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/llc_req_arbiter.md
LLC_REQ_ARBITER -- requirements
Module: llc_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the cache (2..8).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter CACHE_LAT, default 1, cycles from cache_valid to sampled cache_hit/cache_miss (1..7).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 req_addr  input  NUM_REQ x ADDR_W  per-requester address.
REQ-008 req_op  input  NUM_REQ x 2  per-requester operation (0 read, 1 write, 2/3 passed through unchanged).
REQ-009 req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-010 cache_valid  output  1  one-cycle issue strobe to cache.
REQ-011 cache_address  output  ADDR_W  address to cache.
REQ-012 cache_operation  output  2  operation to cache.
REQ-013 cache_hit  input  1  cache hit result.
REQ-014 cache_miss  input  1  cache miss result.
REQ-015 resp_valid  output  NUM_REQ  one-hot one-cycle response strobe.
REQ-016 resp_hit  output  1  hit (1) / miss (0) for the strobed requester.
REQ-017 resp_err  output  1  asserted with resp_valid when cache_hit == cache_miss at sample.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT; exactly one request outstanding at a time.
REQ-019 IDLE: if any req_valid, round-robin winner g selected combinationally, req_ready[g]=1 that cycle, req_addr[g]/req_op[g]/g captured, next state ISSUE; else stay IDLE, req_ready=0.
REQ-020 Round-robin: search starts at (last_grant+1) mod NUM_REQ, wrapping; last_grant updated only on accept.
REQ-021 ISSUE: cache_valid=1 for exactly one cycle with captured address/op; latency counter loaded with CACHE_LAT; next state WAIT.
REQ-022 WAIT: counter decrements each cycle; at value 1, cache_hit/cache_miss sampled, resp_valid[g]=1, resp_hit=cache_hit, resp_err=(cache_hit==cache_miss), next state IDLE.
REQ-023 cache_address/cache_operation hold captured values from ISSUE through WAIT; 0 in IDLE.
REQ-024 Requester must hold req_valid/req_addr/req_op stable until req_ready; deassertion before accept drops the request without effect.
REQ-025 req_valid on the granted requester during ISSUE/WAIT ignored (no second accept until IDLE).
REQ-026 Throughput: one request per CACHE_LAT+2 cycles under continuous load.
REQ-027 resp_hit and resp_err are 0 whenever resp_valid is 0.

Reset
REQ-028 reset=1 at posedge: state IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), counter 0, all outputs 0.
REQ-029 Reset mid-ISSUE/WAIT: outstanding request discarded, no resp_valid produced for it.

Configuration
REQ-030 Macro LLC_ARB_STATS_EN defined: output grant_count (NUM_REQ x 32) counting accepts per requester, wrap at 2^32, and output hit_count (32) counting responses with resp_hit=1; both cleared by reset.
REQ-031 Macro LLC_ARB_STATS_EN undefined: grant_count/hit_count ports and logic absent; all other behaviour identical.

Structure
REQ-032 Package llc_arb_pkg holds: op typedef (OP_READ=0, OP_WRITE=1, OP_2=2, OP_3=3), FSM state typedef, default NUM_REQ/CACHE_LAT constants.
REQ-033 Sub-module rr_arbiter: combinational round-robin picker (inputs request vector, last_grant; outputs one-hot grant, grant index, any).

Verification
REQ-034 Reset, then req_valid=0001, req_addr[0]=0x0000_1000, op=0, cache_hit=1 -> req_ready=0001 in IDLE cycle, cache_valid next cycle with address 0x1000, resp_valid=0001, resp_hit=1 CACHE_LAT cycles later.
REQ-035 All four req_valid held high for 8 accepts -> grant order 0,1,2,3,0,1,2,3; accepts spaced CACHE_LAT+2 cycles.
REQ-036 req_valid=1010 continuously after grant to 3 -> next grant 1, then 3 (wrap-around).
REQ-037 cache_hit=1 and cache_miss=1 at sample -> resp_err=1 with resp_valid; cache_hit=0, cache_miss=1 -> resp_hit=0, resp_err=0.
REQ-038 reset asserted during WAIT of request from requester 2 -> no resp_valid, state IDLE, next grant goes to requester 0.
REQ-039 With LLC_ARB_STATS_EN, 5 accepts from requester 1 with 3 hits -> grant_count[1]=5, hit_count=3; reset clears both.
